// File: rtl/bellek_hakemi.sv
// Shares one external memory port between instruction fetch (l1b) and data (bib).
// Each held request becomes one registered valid/ready access, released by a one-cycle stall drop.
module bellek_hakemi #(
    parameter int ADRES_BIT    = 32,
    parameter int VERI_BIT     = 32,
    parameter int ACLIK_SINIRI = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    l1b_istek_i,
    input  logic [ADRES_BIT-1:0]    l1b_adres_i,
    output logic [VERI_BIT-1:0]     l1b_deger_o,
    output logic                    l1b_bekle_o,
    input  logic                    bib_sec_i,
    input  logic                    bib_yaz_gecerli_i,
    input  logic [ADRES_BIT-1:0]    bib_adr_i,
    input  logic [VERI_BIT-1:0]     bib_veri_i,
    input  logic [VERI_BIT/8-1:0]   bib_veri_maske_i,
    output logic [VERI_BIT-1:0]     bib_veri_o,
    output logic                    bib_durdur_o,
    output logic                    bellek_gecerli_o,
    output logic                    bellek_yaz_o,
    output logic [ADRES_BIT-1:0]    bellek_adr_o,
    output logic [VERI_BIT-1:0]     bellek_veri_o,
    output logic [VERI_BIT/8-1:0]   bellek_maske_o,
    input  logic [VERI_BIT-1:0]     bellek_veri_i,
    input  logic                    bellek_hazir_i
);
    localparam int MASKE_BIT = VERI_BIT / 8;

    typedef enum logic [2:0] {
        BOSTA,
        BUYRUK_BEKLE,
        VERI_BEKLE,
        BUYRUK_BITTI,
        VERI_BITTI
    } durum_t;

    durum_t                 r_durum;
    logic [3:0]             r_sayac;
    logic                   r_gecerli;
    logic                   r_yaz;
    logic [ADRES_BIT-1:0]   r_adr;
    logic [VERI_BIT-1:0]    r_veri;
    logic [MASKE_BIT-1:0]   r_maske;
    logic [VERI_BIT-1:0]    r_l1b_deger;
    logic [VERI_BIT-1:0]    r_bib_veri;

    logic                   w_sinirda;
    logic                   w_veri_kazanir;

    // Data normally has priority; fetch only wins once it has been passed over ACLIK_SINIRI times.
    assign w_sinirda      = (r_sayac == 4'(ACLIK_SINIRI));
    assign w_veri_kazanir = bib_sec_i & ~(l1b_istek_i & w_sinirda);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_durum     <= BOSTA;
            r_sayac     <= '0;
            r_gecerli   <= 1'b0;
            r_yaz       <= 1'b0;
            r_adr       <= '0;
            r_veri      <= '0;
            r_maske     <= '0;
            r_l1b_deger <= '0;
            r_bib_veri  <= '0;
        end else begin
            case (r_durum)
                BOSTA: begin
                    if (!l1b_istek_i)
                        r_sayac <= '0;
                    if (w_veri_kazanir) begin
                        r_gecerli <= 1'b1;
                        r_yaz     <= bib_yaz_gecerli_i;
                        r_adr     <= bib_adr_i;
                        r_veri    <= bib_veri_i;
                        r_maske   <= bib_veri_maske_i;
                        r_durum   <= VERI_BEKLE;
                        if (l1b_istek_i && !w_sinirda)
                            r_sayac <= r_sayac + 4'd1;
                    end else if (l1b_istek_i) begin
                        r_gecerli <= 1'b1;
                        r_yaz     <= 1'b0;
                        r_adr     <= l1b_adres_i;
                        r_veri    <= '0;
                        r_maske   <= '0;
                        r_sayac   <= '0;
                        r_durum   <= BUYRUK_BEKLE;
                    end
                end
                BUYRUK_BEKLE: begin
                    if (bellek_hazir_i) begin
                        r_gecerli   <= 1'b0;
                        r_l1b_deger <= bellek_veri_i;
                        r_durum     <= BUYRUK_BITTI;
                    end
                end
                VERI_BEKLE: begin
                    if (bellek_hazir_i) begin
                        r_gecerli <= 1'b0;
                        if (!r_yaz)
                            r_bib_veri <= bellek_veri_i;
                        r_durum <= VERI_BITTI;
                    end
                end
                BUYRUK_BITTI: r_durum <= BOSTA;
                VERI_BITTI:   r_durum <= BOSTA;
                default:      r_durum <= BOSTA;
            endcase
        end
    end

    assign bellek_gecerli_o = r_gecerli;
    assign bellek_yaz_o     = r_yaz;
    assign bellek_adr_o     = r_adr;
    assign bellek_veri_o    = r_veri;
    assign bellek_maske_o   = r_maske;
    assign l1b_deger_o      = r_l1b_deger;
    assign bib_veri_o       = r_bib_veri;

    // The stall drops for exactly the completion cycle of the requester's own access.
    assign l1b_bekle_o  = l1b_istek_i & (r_durum != BUYRUK_BITTI);
    assign bib_durdur_o = bib_sec_i & (r_durum != VERI_BITTI);
endmodule

// File: tb/tb_bellek_hakemi.sv
// Self-checking bench for bellek_hakemi: vector table with a scoreboard queue,
// plus hand-written sequences for arbitration fairness, reset and back-to-back fetches.
module tb_bellek_hakemi;
    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        l1b_istek_i;
    logic [31:0] l1b_adres_i;
    logic [31:0] l1b_deger_o;
    logic        l1b_bekle_o;
    logic        bib_sec_i;
    logic        bib_yaz_gecerli_i;
    logic [31:0] bib_adr_i;
    logic [31:0] bib_veri_i;
    logic [3:0]  bib_veri_maske_i;
    logic [31:0] bib_veri_o;
    logic        bib_durdur_o;
    logic        bellek_gecerli_o;
    logic        bellek_yaz_o;
    logic [31:0] bellek_adr_o;
    logic [31:0] bellek_veri_o;
    logic [3:0]  bellek_maske_o;
    logic [31:0] bellek_veri_i;
    logic        bellek_hazir_i;

    always #5 clk_i = ~clk_i;

    bellek_hakemi #(
        .ADRES_BIT   (32),
        .VERI_BIT    (32),
        .ACLIK_SINIRI(2)
    ) dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .l1b_istek_i      (l1b_istek_i),
        .l1b_adres_i      (l1b_adres_i),
        .l1b_deger_o      (l1b_deger_o),
        .l1b_bekle_o      (l1b_bekle_o),
        .bib_sec_i        (bib_sec_i),
        .bib_yaz_gecerli_i(bib_yaz_gecerli_i),
        .bib_adr_i        (bib_adr_i),
        .bib_veri_i       (bib_veri_i),
        .bib_veri_maske_i (bib_veri_maske_i),
        .bib_veri_o       (bib_veri_o),
        .bib_durdur_o     (bib_durdur_o),
        .bellek_gecerli_o (bellek_gecerli_o),
        .bellek_yaz_o     (bellek_yaz_o),
        .bellek_adr_o     (bellek_adr_o),
        .bellek_veri_o    (bellek_veri_o),
        .bellek_maske_o   (bellek_maske_o),
        .bellek_veri_i    (bellek_veri_i),
        .bellek_hazir_i   (bellek_hazir_i)
    );

    typedef struct {
        bit          fetch;
        bit          yaz;
        logic [31:0] adr;
        logic [31:0] veri;
        logic [3:0]  maske;
        logic [31:0] bellek_veri;
        int          bekleme;
        logic [31:0] e_veri;
        logic [3:0]  e_maske;
        logic [31:0] e_l1b;
        logic [31:0] e_bib;
    } vek_t;

    vek_t tablo [6];
    vek_t sb_vek [$];
    bit   sb_sira [$];

    int n_toplam = 0;
    int n_gecti  = 0;

    task automatic kontrol(input string ad, input logic [63:0] gercek, input logic [63:0] beklenen);
        n_toplam++;
        if (gercek === beklenen)
            n_gecti++;
        else
            $display("FAIL %s: gercek=%h beklenen=%h", ad, gercek, beklenen);
    endtask

    function automatic logic bekle_sinyali(input bit fetch);
        return fetch ? l1b_bekle_o : bib_durdur_o;
    endfunction

    task automatic uygula(input vek_t v, input int idx);
        vek_t e;
        int   n;
        @(negedge clk_i);
        l1b_istek_i       = v.fetch;
        l1b_adres_i       = v.fetch ? v.adr : 32'hBAD0_0000;
        bib_sec_i         = !v.fetch;
        bib_yaz_gecerli_i = v.yaz;
        bib_adr_i         = v.fetch ? ~v.adr : v.adr;
        bib_veri_i        = v.veri;
        bib_veri_maske_i  = v.maske;
        sb_vek.push_back(v);
        #1 kontrol("bekle_c0", bekle_sinyali(v.fetch), 1'b1);
        n = 0;
        while (!bellek_gecerli_o && n < 20) begin
            @(negedge clk_i);
            n++;
        end
        kontrol("gecikme", n, 1);
        e = sb_vek.pop_front();
        kontrol("bellek_yaz_adr", {bellek_yaz_o, bellek_adr_o}, {e.yaz, e.adr});
        kontrol("bellek_maske_veri", {bellek_maske_o, bellek_veri_o}, {e.e_maske, e.e_veri});
        kontrol("bekle_c1", bekle_sinyali(e.fetch), 1'b1);
        for (int w = 0; w < e.bekleme; w++) begin
            @(negedge clk_i);
            kontrol("kararli_adr", {bellek_gecerli_o, bekle_sinyali(e.fetch), bellek_yaz_o, bellek_adr_o},
                    {1'b1, 1'b1, e.yaz, e.adr});
            kontrol("kararli_veri", {bellek_maske_o, bellek_veri_o}, {e.e_maske, e.e_veri});
        end
        bellek_hazir_i = 1'b1;
        bellek_veri_i  = e.bellek_veri;
        @(negedge clk_i);
        bellek_hazir_i = 1'b0;
        bellek_veri_i  = '0;
        kontrol("serbest", {bellek_gecerli_o, bekle_sinyali(e.fetch)}, 2'b00);
        kontrol("l1b_deger", l1b_deger_o, e.e_l1b);
        kontrol("bib_veri", bib_veri_o, e.e_bib);
        $display("islem %0d: %s yaz=%0b adr=%h bekleme=%0d l1b=%h bib=%h", idx,
                 e.fetch ? "getir" : "veri", e.yaz, e.adr, e.bekleme, l1b_deger_o, bib_veri_o);
        l1b_istek_i = 1'b0;
        bib_sec_i   = 1'b0;
        @(negedge clk_i);
        kontrol("bosta", {bellek_gecerli_o, l1b_bekle_o, bib_durdur_o}, 3'b000);
    endtask

    // Zero-wait memory response to whichever access is granted next.
    task automatic hizmet(output bit fetch_kazandi, output int gec, output logic [31:0] adr);
        gec = 0;
        while (!bellek_gecerli_o && gec < 20) begin
            @(negedge clk_i);
            gec++;
        end
        adr            = bellek_adr_o;
        fetch_kazandi  = (bellek_adr_o == l1b_adres_i);
        bellek_hazir_i = 1'b1;
        bellek_veri_i  = 32'h5A5A_0000 ^ bellek_adr_o;
        @(negedge clk_i);
        bellek_hazir_i = 1'b0;
        bellek_veri_i  = '0;
        $display("hizmet: %s adr=%h gecikme=%0d", fetch_kazandi ? "getir" : "veri", adr, gec);
    endtask

    initial begin
        bit          f;
        int          g;
        logic [31:0] a;
        int          n;

        tablo[0] = '{1, 0, 32'h0000_0100, 32'hFFFF_0000, 4'hF, 32'h0000_0013, 0,
                     32'h0, 4'h0, 32'h0000_0013, 32'h0};
        tablo[1] = '{0, 0, 32'h2000_0010, 32'h0BAD_0BAD, 4'hF, 32'hCAFE_F00D, 1,
                     32'h0BAD_0BAD, 4'hF, 32'h0000_0013, 32'hCAFE_F00D};
        tablo[2] = '{0, 1, 32'h8000_0004, 32'hDEAD_BEEF, 4'b0011, 32'h7777_7777, 3,
                     32'hDEAD_BEEF, 4'b0011, 32'h0000_0013, 32'hCAFE_F00D};
        tablo[3] = '{0, 1, 32'h0000_0044, 32'h1234_5678, 4'b0000, 32'h0000_0099, 0,
                     32'h1234_5678, 4'b0000, 32'h0000_0013, 32'hCAFE_F00D};
        tablo[4] = '{1, 0, 32'h0000_0104, 32'h5555_5555, 4'hA, 32'h00A0_0093, 2,
                     32'h0, 4'h0, 32'h00A0_0093, 32'hCAFE_F00D};
        tablo[5] = '{0, 0, 32'h0000_1FFC, 32'h0, 4'h0, 32'hFFFF_FFFF, 0,
                     32'h0, 4'h0, 32'h00A0_0093, 32'hFFFF_FFFF};

        rst_i             = 1'b1;
        l1b_istek_i       = 1'b0;
        l1b_adres_i       = '0;
        bib_sec_i         = 1'b0;
        bib_yaz_gecerli_i = 1'b0;
        bib_adr_i         = '0;
        bib_veri_i        = '0;
        bib_veri_maske_i  = '0;
        bellek_veri_i     = '0;
        bellek_hazir_i    = 1'b0;
        #1;
        kontrol("reset_bellek", {bellek_gecerli_o, bellek_yaz_o, bellek_adr_o, bellek_maske_o}, '0);
        kontrol("reset_veri", {l1b_deger_o, bib_veri_o}, '0);
        @(negedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;

        for (int i = 0; i < 6; i++)
            uygula(tablo[i], i);

        // Both sides requesting continuously: data, data, fetch repeating.
        @(negedge clk_i);
        l1b_istek_i       = 1'b1;
        l1b_adres_i       = 32'h0000_0300;
        bib_sec_i         = 1'b1;
        bib_yaz_gecerli_i = 1'b0;
        bib_adr_i         = 32'h0000_0400;
        bib_veri_maske_i  = 4'h0;
        sb_sira = '{0, 0, 1, 0, 0, 1, 0, 0};
        while (sb_sira.size() > 0) begin
            hizmet(f, g, a);
            kontrol("sira", f, sb_sira.pop_front());
        end
        // Counter now saturated; an idle BOSTA cycle without fetch must clear it.
        l1b_istek_i = 1'b0;
        bib_sec_i   = 1'b0;
        @(negedge clk_i);
        @(negedge clk_i);
        kontrol("bosta_gecerli", bellek_gecerli_o, 1'b0);
        l1b_istek_i = 1'b1;
        bib_sec_i   = 1'b1;
        hizmet(f, g, a);
        kontrol("temiz_sayac_veri", {f, g[7:0]}, {1'b0, 8'd1});
        bib_sec_i = 1'b0;
        hizmet(f, g, a);
        kontrol("yalniz_getir", {f, g[7:0]}, {1'b1, 8'd2});
        kontrol("yalniz_getir_deger", l1b_deger_o, 32'h5A5A_0300);
        l1b_istek_i = 1'b0;

        // Reset in the middle of a data read; the late ready must be ignored.
        @(negedge clk_i);
        bib_sec_i = 1'b1;
        bib_adr_i = 32'h0000_0500;
        n = 0;
        while (!bellek_gecerli_o && n < 20) begin
            @(negedge clk_i);
            n++;
        end
        kontrol("rst_oncesi_gecerli", bellek_gecerli_o, 1'b1);
        @(negedge clk_i);
        rst_i = 1'b1;
        #1;
        kontrol("rst_gecerli", bellek_gecerli_o, 1'b0);
        kontrol("rst_bib_veri", bib_veri_o, 32'h0);
        kontrol("rst_adr", bellek_adr_o, 32'h0);
        bib_sec_i = 1'b0;
        @(negedge clk_i);
        rst_i          = 1'b0;
        bellek_hazir_i = 1'b1;
        bellek_veri_i  = 32'h1234_ABCD;
        @(negedge clk_i);
        bellek_hazir_i = 1'b0;
        bellek_veri_i  = '0;
        kontrol("gec_hazir_yok", {bellek_gecerli_o, bib_veri_o, l1b_deger_o}, '0);

        // Back-to-back fetches with the address advanced in the release cycle.
        l1b_istek_i = 1'b1;
        l1b_adres_i = 32'h0000_0700;
        hizmet(f, g, a);
        kontrol("ilk_getir", {f, g[7:0], a}, {1'b1, 8'd1, 32'h0000_0700});
        kontrol("ilk_serbest", l1b_bekle_o, 1'b0);
        l1b_adres_i = 32'h0000_0704;
        hizmet(f, g, a);
        kontrol("ardisik_getir", {f, g[7:0], a}, {1'b1, 8'd2, 32'h0000_0704});
        kontrol("ardisik_deger", l1b_deger_o, 32'h5A5A_0704);
        l1b_istek_i = 1'b0;
        @(negedge clk_i);

        $display("%0d/%0d checks passed", n_gecti, n_toplam);
        $finish;
    end
endmodule
